uart_tx_port: RTL and testbench

Register-bus UART transmitter peripheral for the ulisp microcontroller. It sits beside the board-level register decoder on the same `register_index`/`register_write`/`register_read` bus. Bytes written by Lisp code are queued in a small FIFO and shifted out as 8N1 serial frames on `uart_tx`. A status register lets software poll for busy, full and overflow conditions.

---
 rtl/uart_tx_port.sv | 240 ++++++++++++++++++++++++
 tb/tb_uart_tx_port.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_port.sv
// Register-bus 8N1 UART transmitter with a status register (busy/full/overflow).
// Build option: define UART_TX_FIFO_EN for a FIFO_DEPTH queue, otherwise a single holding register.
module uart_tx_port #(
    parameter int CLOCKS_PER_BIT = 217,
    parameter int FIFO_DEPTH     = 8,
    parameter int BASE_INDEX     = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  register_index,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    input  logic        register_read,
    output logic [15:0] register_read_value,
    output logic        uart_tx
);
    // state  | meaning
    // IDLE   | line high, waiting for a queued byte
    // START  | start bit (low)
    // DATA   | eight data bits, LSB first
    // STOP   | stop bit (high); may chain straight into the next START
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam logic [6:0]  DATA_IDX = 7'(BASE_INDEX);
    localparam logic [6:0]  STAT_IDX = 7'(BASE_INDEX + 1);
    localparam logic [15:0] BIT_LOAD = 16'(CLOCKS_PER_BIT - 1);

    logic        data_wr, status_rd, data_rd;
    logic        pop, push_ok, ovf_set;
    logic        full, empty, busy;
    logic [7:0]  head;
    logic [7:0]  wdata;
    logic        unused_hi;

    assign data_wr   = register_write && (register_index == DATA_IDX);
    assign status_rd = register_read && (register_index == STAT_IDX);
    assign data_rd   = register_read && (register_index == DATA_IDX);
    assign wdata     = register_write_value[7:0];
    assign unused_hi = ^register_write_value[15:8];

    // A pop on the same edge frees a slot, so a write to a full queue still lands.
    assign push_ok = data_wr && (!full || pop);
    assign ovf_set = data_wr && full && !pop;

`ifdef UART_TX_FIFO_EN
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [7:0]     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
`else
    localparam int unused_depth = FIFO_DEPTH;

    logic [7:0] hold_q, hold_d;
    logic       hold_valid_q, hold_valid_d;

    assign full  = hold_valid_q;
    assign empty = !hold_valid_q;
    assign head  = hold_q;

    always_comb begin
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        if (push_ok) begin
            hold_d       = wdata;
            hold_valid_d = 1'b1;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end
`endif

    logic [1:0]  state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        overflow_q, overflow_d;
    logic [15:0] rd_val_q, rd_val_d;
    logic        timer_done;

    assign timer_done = (timer_q == 16'd0);
    assign busy       = !empty || (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    timer_d = BIT_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (timer_done) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 3'd0;
                    timer_d   = BIT_LOAD;
                    state_d   = ST_DATA;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_done) begin
                    timer_d = BIT_LOAD;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (timer_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        tx_d    = 1'b0;
                        timer_d = BIT_LOAD;
                        state_d = ST_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Status read returns the pre-edge overflow; a same-edge overflow leaves it set.
    always_comb begin
        overflow_d = (overflow_q && !status_rd) || ovf_set;
        rd_val_d   = rd_val_q;
        if (status_rd) begin
            rd_val_d = {13'd0, overflow_q, full, busy};
        end else if (data_rd) begin
            rd_val_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            rd_val_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            rd_val_q   <= rd_val_d;
        end
    end

    assign uart_tx             = tx_q;
    assign register_read_value = rd_val_q;

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: expected frames and read values are queued by
// the stimulus and checked by independent serial-line and read-data monitors.
module tb_uart_tx_port;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    typedef struct {
        logic [7:0] b;
        int         mode;   // 0 any start, 1 exact start cycle, 2 contiguous, 3 aborted by reset
        int         start;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  register_index = '0;
    logic        register_write = 1'b0;
    logic [15:0] register_write_value = '0;
    logic        register_read = 1'b0;
    logic [15:0] register_read_value;
    logic        uart_tx;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t        exp_q[$];
    logic [15:0] rd_q[$];

    uart_tx_port #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(4), .BASE_INDEX(7)) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read        (register_read),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int target);
        while (cyc < target) tick();
    endtask

    task automatic push_frame(input logic [7:0] b, input int mode, input int start);
        exp_t e;
        e.b = b; e.mode = mode; e.start = start;
        exp_q.push_back(e);
    endtask

    task automatic wr(input logic [7:0] b);
        register_index       = 7'd7;
        register_write_value = {8'hA5, b};
        register_write       = 1'b1;
        tick();
        register_write       = 1'b0;
    endtask

    task automatic rd(input logic [6:0] idx, input logic [15:0] expv);
        rd_q.push_back(expv);
        register_index = idx;
        register_read  = 1'b1;
        tick();
        register_read  = 1'b0;
    endtask

    task automatic wait_frames(input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL frame_timeout: %0d frames outstanding, required 0", exp_q.size());
        end
        repeat (4) tick();
    endtask

    // Read-data monitor
    initial begin : read_mon
        logic [15:0] e;
        forever begin
            @(posedge clk);
            if (register_read === 1'b1 && reset !== 1'b1) begin
                @(negedge clk);
                tests++;
                if (rd_q.size() == 0) begin
                    fails++;
                    $display("FAIL read_unexpected: got %h with nothing queued", register_read_value);
                end else begin
                    e = rd_q.pop_front();
                    if (register_read_value !== e) begin
                        fails++;
                        $display("FAIL read_value @%0d: got %h, required %h", cyc, register_read_value, e);
                    end
                end
            end
        end
    end

    // Serial-line monitor
    initial begin : frame_mon
        int         s, k, last_start;
        logic [7:0] got;
        logic       shape_ok, aborted;
        exp_t       e;
        last_start = -1000;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1 && uart_tx === 1'b0) begin
                s = cyc; got = '0; shape_ok = 1'b1; aborted = 1'b0;
                for (int i = 0; i < FRAME; i++) begin
                    if (i != 0) @(negedge clk);
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    k = i / CPB;
                    if (k == 0) begin
                        if (uart_tx !== 1'b0) shape_ok = 1'b0;
                    end else if (k == 9) begin
                        if (uart_tx !== 1'b1) shape_ok = 1'b0;
                    end else if (i % CPB == 0) begin
                        got[k-1] = uart_tx;
                    end else if (uart_tx !== got[k-1]) begin
                        shape_ok = 1'b0;
                    end
                end
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL frame_unexpected: got frame %h at %0d, required none", got, s);
                end else begin
                    e = exp_q.pop_front();
                    if (aborted || e.mode == 3) begin
                        if (!(aborted && e.mode == 3)) begin
                            fails++;
                            $display("FAIL frame_abort: got aborted=%0d, required aborted=%0d", aborted, e.mode == 3);
                        end
                    end else begin
                        if (got !== e.b) begin
                            fails++;
                            $display("FAIL frame_byte: got %h, required %h", got, e.b);
                        end
                        tests++;
                        if (!shape_ok) begin
                            fails++;
                            $display("FAIL frame_shape: byte %h got malformed bit timing, required %0d-cycle bits", e.b, CPB);
                        end
                        if (e.mode == 1) begin
                            tests++;
                            if (s != e.start) begin
                                fails++;
                                $display("FAIL frame_latency: got start %0d, required %0d", s, e.start);
                            end
                        end else if (e.mode == 2) begin
                            tests++;
                            if (s != last_start + FRAME) begin
                                fails++;
                                $display("FAIL frame_gap: got start %0d, required %0d", s, last_start + FRAME);
                            end
                        end
                    end
                end
                last_start = s;
            end
        end
    end

    initial begin : stim
        int w;
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        // Reset
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++;
        if (uart_tx !== 1'b1) begin
            fails++;
            $display("FAIL reset_tx: got %b, required 1", uart_tx);
        end
        tick();
        rd(7'd8, 16'h0000);

        // Single byte
        w = cyc;
        push_frame(8'h55, 1, w + 2);
        wr(8'h55);
        tick();
        rd(7'd8, 16'h0001);
        rd(7'd3, 16'h0001);
        rd(7'd7, 16'h0000);
        wait_frames(200);
        rd(7'd8, 16'h0000);

        // Back-to-back
        w = cyc;
        push_frame(8'h01, 1, w + 2);
        wr(8'h01);
        push_frame(8'h80, 2, 0);
        wr(8'h80);
        if (D > 1) push_frame(8'hFF, 2, 0);
        wr(8'hFF);
        rd(7'd8, (D > 1) ? 16'h0001 : 16'h0007);
        wait_frames(300);
        rd(7'd8, 16'h0000);

        // Overflow
        w = cyc;
        push_frame(8'hA0, 1, w + 2);
        wr(8'hA0);
        tick();
        for (int i = 0; i < D; i++) begin
            push_frame(fill[i], 2, 0);
            wr(fill[i]);
        end
        rd(7'd8, 16'h0003);
        wr(8'hEE);
        rd(7'd8, 16'h0007);
        rd(7'd8, 16'h0003);
        wait_frames(400);
        rd(7'd8, 16'h0000);

        // Full queue with a write on the edge the STOP bit ends
        w = cyc;
        push_frame(8'h5A, 1, w + 2);
        wr(8'h5A);
        tick();
        for (int i = 0; i < D; i++) begin
            push_frame(fill[i] ^ 8'hC3, 2, 0);
            wr(fill[i] ^ 8'hC3);
        end
        tick_until(w + 41);
        push_frame(8'hF0, 2, 0);
        wr(8'hF0);
        rd(7'd8, 16'h0003);
        wait_frames(400);
        rd(7'd8, 16'h0000);

        // Reset during DATA bit 3
        w = cyc;
        push_frame(8'h00, 3, 0);
        wr(8'h00);
        tick_until(w + 19);
        reset = 1'b1;
        tick();
        tests++;
        if (uart_tx !== 1'b1) begin
            fails++;
            $display("FAIL reset_midframe_tx: got %b, required 1", uart_tx);
        end
        tick();
        reset = 1'b0;
        tick();
        rd(7'd8, 16'h0000);
        repeat (100) tick();

        tests++;
        if (exp_q.size() != 0 || rd_q.size() != 0) begin
            fails++;
            $display("FAIL leftover: got %0d frames / %0d reads pending, required 0", exp_q.size(), rd_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
